// File: rtl/cvxif_bcd_exec.sv
// CV-X-IF example coprocessor execution unit: BCDfromBIN (double-dabble) and BCDADD.
// Optional macro CVXIF_BCD_FAST_EN: single-cycle parallel-carry BCDADD instead of digit-serial.
module cvxif_bcd_exec #(
    parameter int ID_WIDTH = 4,
    parameter int XLEN     = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [3:0]          req_opcode_i,
    input  logic [XLEN-1:0]     req_rs1_i,
    input  logic [XLEN-1:0]     req_rs2_i,
    input  logic [4:0]          req_rd_i,
    input  logic [ID_WIDTH-1:0] req_id_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [XLEN-1:0]     res_data_o,
    output logic [4:0]          res_rd_o,
    output logic [ID_WIDTH-1:0] res_id_o,
    output logic                res_we_o,
    output logic                res_exc_o,
    output logic [1:0]          res_flags_o,
    output logic [1:0]          dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] OP_BIN2BCD = 4'd1;
    localparam logic [3:0] OP_BCDADD  = 4'd2;

    // Handshakes: a request transfers on an edge where req_valid_i & req_ready_o;
    // a result transfers on an edge where res_valid_o & res_ready_i. flush_i wins over both.
    state_t              state;
    logic [4:0]          cnt;
    logic [3:0]          op;
    logic [XLEN-1:0]     opa;
    logic [XLEN-1:0]     opb;
    logic [39:0]         bcd;
    logic [39:0]         bcd_adj;
    logic [XLEN-1:0]     sum;
    logic                carry;
    logic                inv;
    logic [4:0]          rd;
    logic [ID_WIDTH-1:0] id;

    assign req_ready_o = (state == IDLE);
    assign dbg_state_o = state;

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < 10; i++) begin
            bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        end
    end

`ifdef CVXIF_BCD_FAST_EN
    logic [XLEN-1:0] fast_sum;
    logic [4:0]      fast_ds;
    logic            fast_c;
    logic            fast_inv;

    always_comb begin
        fast_sum = '0;
        fast_ds  = '0;
        fast_c   = 1'b0;
        fast_inv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            fast_inv = fast_inv | (opa[4*i +: 4] > 4'd9) | (opb[4*i +: 4] > 4'd9);
            fast_ds  = {1'b0, opa[4*i +: 4]} + {1'b0, opb[4*i +: 4]} + {4'b0, fast_c};
            fast_c   = (fast_ds > 5'd9);
            fast_sum[4*i +: 4] = fast_c ? fast_ds[3:0] - 4'd10 : fast_ds[3:0];
        end
    end
`else
    logic [4:0] ser_ds;
    logic [3:0] ser_dig;
    logic       ser_c;
    logic       ser_inv;

    // Operands shift right one digit per cycle, so the active digit is always the low nibble.
    always_comb begin
        ser_ds  = {1'b0, opa[3:0]} + {1'b0, opb[3:0]} + {4'b0, carry};
        ser_c   = (ser_ds > 5'd9);
        ser_dig = ser_c ? ser_ds[3:0] - 4'd10 : ser_ds[3:0];
        ser_inv = (opa[3:0] > 4'd9) | (opb[3:0] > 4'd9);
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            op          <= '0;
            opa         <= '0;
            opb         <= '0;
            bcd         <= '0;
            sum         <= '0;
            carry       <= 1'b0;
            inv         <= 1'b0;
            rd          <= '0;
            id          <= '0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_rd_o    <= '0;
            res_id_o    <= '0;
            res_we_o    <= 1'b0;
            res_exc_o   <= 1'b0;
            res_flags_o <= '0;
        end else if (flush_i) begin
            state       <= IDLE;
            cnt         <= '0;
            res_valid_o <= 1'b0;
            res_data_o  <= '0;
            res_rd_o    <= '0;
            res_id_o    <= '0;
            res_we_o    <= 1'b0;
            res_exc_o   <= 1'b0;
            res_flags_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        op    <= req_opcode_i;
                        opa   <= req_rs1_i;
                        opb   <= req_rs2_i;
                        rd    <= req_rd_i;
                        id    <= req_id_i;
                        bcd   <= '0;
                        sum   <= '0;
                        carry <= 1'b0;
                        inv   <= 1'b0;
                        cnt   <= '0;
                        case (req_opcode_i)
                            OP_BIN2BCD: state <= CONV;
                            OP_BCDADD:  state <= ADD;
                            default:    state <= DONE;
                        endcase
                    end
                end
                CONV: begin
                    bcd <= {bcd_adj[38:0], opa[XLEN-1]};
                    opa <= {opa[XLEN-2:0], 1'b0};
                    if (cnt == 5'd31) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ADD: begin
`ifdef CVXIF_BCD_FAST_EN
                    sum   <= fast_sum;
                    carry <= fast_c;
                    inv   <= fast_inv;
                    state <= DONE;
`else
                    sum   <= {ser_dig, sum[XLEN-1:4]};
                    carry <= ser_c;
                    inv   <= inv | ser_inv;
                    opa   <= {4'b0, opa[XLEN-1:4]};
                    opb   <= {4'b0, opb[XLEN-1:4]};
                    if (cnt == 5'd7) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
`endif
                end
                DONE: begin
                    // First DONE cycle registers the result beat; it is then held until taken.
                    if (!res_valid_o) begin
                        res_valid_o <= 1'b1;
                        res_rd_o    <= rd;
                        res_id_o    <= id;
                        case (op)
                            OP_BIN2BCD: begin
                                res_data_o  <= bcd[XLEN-1:0];
                                res_flags_o <= {1'b0, |bcd[39:32]};
                                res_we_o    <= (rd != 5'd0);
                                res_exc_o   <= 1'b0;
                            end
                            OP_BCDADD: begin
                                res_data_o  <= inv ? '0 : sum;
                                res_flags_o <= {inv, ~inv & carry};
                                res_we_o    <= (rd != 5'd0);
                                res_exc_o   <= 1'b0;
                            end
                            default: begin
                                res_data_o  <= '0;
                                res_flags_o <= '0;
                                res_we_o    <= 1'b0;
                                res_exc_o   <= 1'b1;
                            end
                        endcase
                    end else if (res_ready_i) begin
                        state       <= IDLE;
                        res_valid_o <= 1'b0;
                        res_data_o  <= '0;
                        res_rd_o    <= '0;
                        res_id_o    <= '0;
                        res_we_o    <= 1'b0;
                        res_exc_o   <= 1'b0;
                        res_flags_o <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cvxif_bcd_exec.sv
// Bench for cvxif_bcd_exec: directed vector table, hand-written flush/reset/backpressure
// sequences and randomized requests checked against an arithmetic reference model.
module tb_cvxif_bcd_exec;
  localparam int ID_WIDTH = 4;
  localparam int XLEN     = 32;
  localparam int EW       = 45;
  localparam int CONV_LAT = 33;
  localparam int ILL_LAT  = 1;
`ifdef CVXIF_BCD_FAST_EN
  localparam int ADD_LAT  = 2;
`else
  localparam int ADD_LAT  = 9;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                flush = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [3:0]          req_opcode = '0;
  logic [XLEN-1:0]     req_rs1 = '0;
  logic [XLEN-1:0]     req_rs2 = '0;
  logic [4:0]          req_rd = '0;
  logic [ID_WIDTH-1:0] req_id = '0;
  logic                res_valid;
  logic                res_ready = 1'b0;
  logic [XLEN-1:0]     res_data;
  logic [4:0]          res_rd;
  logic [ID_WIDTH-1:0] res_id;
  logic                res_we;
  logic                res_exc;
  logic [1:0]          res_flags;
  logic [1:0]          dbg_state;
  logic [EW-1:0]       act_vec;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] exp_q[$];
  int            lat_q[$];

  cvxif_bcd_exec #(.ID_WIDTH(ID_WIDTH), .XLEN(XLEN)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_opcode_i(req_opcode),
    .req_rs1_i   (req_rs1),
    .req_rs2_i   (req_rs2),
    .req_rd_i    (req_rd),
    .req_id_i    (req_id),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .res_rd_o    (res_rd),
    .res_id_o    (res_id),
    .res_we_o    (res_we),
    .res_exc_o   (res_exc),
    .res_flags_o (res_flags),
    .dbg_state_o (dbg_state)
  );

  assign act_vec = {res_data, res_rd, res_id, res_we, res_exc, res_flags};

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [31:0] to_bcd8(input longint v);
    logic [31:0] r;
    longint t;
    r = '0;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [31:0] x);
    for (int i = 0; i < 8; i++) if (x[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint from_bcd8(input logic [31:0] x);
    longint v;
    longint p;
    v = 0;
    p = 1;
    for (int i = 0; i < 8; i++) begin
      v = v + longint'(x[4*i +: 4]) * p;
      p = p * 10;
    end
    return v;
  endfunction

  function automatic logic [EW-1:0] pack_exp(input logic [31:0] data, input logic [4:0] rd,
                                             input logic [3:0] id, input logic we,
                                             input logic exc, input logic [1:0] flags);
    return {data, rd, id, we, exc, flags};
  endfunction

  task automatic model(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [3:0] id,
                       output logic [EW-1:0] ev, output int lat);
    longint v;
    if (op == 4'd1) begin
      v = longint'({32'b0, rs1});
      ev = pack_exp(to_bcd8(v % 100000000), rd, id, rd != 0, 1'b0, {1'b0, v >= 100000000});
      lat = CONV_LAT;
    end else if (op == 4'd2) begin
      if (!(bcd_ok(rs1) && bcd_ok(rs2))) begin
        ev = pack_exp(32'h0, rd, id, rd != 0, 1'b0, 2'b10);
      end else begin
        v = from_bcd8(rs1) + from_bcd8(rs2);
        ev = pack_exp(to_bcd8(v % 100000000), rd, id, rd != 0, 1'b0, {1'b0, v >= 100000000});
      end
      lat = ADD_LAT;
    end else begin
      ev = pack_exp(32'h0, rd, id, 1'b0, 1'b1, 2'b00);
      lat = ILL_LAT;
    end
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic accept_only(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [4:0] rd, input logic [3:0] id, output bit ok);
    int guard;
    @(negedge clk);
    req_opcode = op;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_rd     = rd;
    req_id     = id;
    req_valid  = 1'b1;
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    ok = req_ready;
    if (ok) @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    int k;
    logic [EW-1:0] e;
    logic [EW-1:0] snap;
    int l;
    k = 0;
    @(negedge clk);
    while (!res_valid && k < 200) begin
      k++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    if (!res_valid) begin
      check("result_timeout", 64'(res_valid), 64'(1));
      return;
    end
    check("latency", 64'(k), 64'(l));
    check("result", 64'(act_vec), 64'(e));
    check("req_ready_busy", 64'(req_ready), 64'(0));
    snap = act_vec;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(res_valid), 64'(1));
      check("hold_stable", 64'(act_vec), 64'(snap));
      check("hold_req_ready", 64'(req_ready), 64'(0));
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("post_hs_valid", 64'(res_valid), 64'(0));
    check("post_hs_req_ready", 64'(req_ready), 64'(1));
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [3:0] id,
                       input logic [EW-1:0] ev, input int lat, input int hold);
    bit ok;
    exp_q.push_back(ev);
    lat_q.push_back(lat);
    accept_only(op, rs1, rs2, rd, id, ok);
    if (!ok) begin
      check("accept_timeout", 64'(ok), 64'(1));
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      return;
    end
    collect(hold);
  endtask

  task automatic watch_no_beat(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check(name, 64'(seen), 64'(0));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  flags;
    logic        we;
    logic        exc;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [EW-1:0] ev;
    int lat;
    bit ok;
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;
    int sel;

    vecs[0]  = '{4'd1, 32'h00BC614E, 32'h0,        5'd5,  4'd3,  32'h12345678, 2'b00, 1'b1, 1'b0, CONV_LAT, 5};
    vecs[1]  = '{4'd1, 32'h05F5E100, 32'h0,        5'd1,  4'd4,  32'h00000000, 2'b01, 1'b1, 1'b0, CONV_LAT, 0};
    vecs[2]  = '{4'd1, 32'hFFFFFFFF, 32'h0,        5'd2,  4'd5,  32'h94967295, 2'b01, 1'b1, 1'b0, CONV_LAT, 1};
    vecs[3]  = '{4'd1, 32'h05F5E0FF, 32'hDEAD,     5'd6,  4'd7,  32'h99999999, 2'b00, 1'b1, 1'b0, CONV_LAT, 0};
    vecs[4]  = '{4'd1, 32'h00000000, 32'h0,        5'd0,  4'd8,  32'h00000000, 2'b00, 1'b0, 1'b0, CONV_LAT, 0};
    vecs[5]  = '{4'd2, 32'h00000999, 32'h00000001, 5'd3,  4'd6,  32'h00001000, 2'b00, 1'b1, 1'b0, ADD_LAT,  2};
    vecs[6]  = '{4'd2, 32'h99999999, 32'h00000001, 5'd4,  4'd2,  32'h00000000, 2'b01, 1'b1, 1'b0, ADD_LAT,  0};
    vecs[7]  = '{4'd2, 32'h0000000A, 32'h00000000, 5'd7,  4'd9,  32'h00000000, 2'b10, 1'b1, 1'b0, ADD_LAT,  0};
    vecs[8]  = '{4'd2, 32'h00001234, 32'h00005678, 5'd0,  4'd1,  32'h00006912, 2'b00, 1'b0, 1'b0, ADD_LAT,  0};
    vecs[9]  = '{4'd2, 32'h50000000, 32'h50000000, 5'd11, 4'd12, 32'h00000000, 2'b01, 1'b1, 1'b0, ADD_LAT,  0};
    vecs[10] = '{4'd2, 32'hF0000000, 32'h00000001, 5'd12, 4'd13, 32'h00000000, 2'b10, 1'b1, 1'b0, ADD_LAT,  0};
    vecs[11] = '{4'd7, 32'h12345678, 32'h1,        5'd9,  4'd1,  32'h00000000, 2'b00, 1'b0, 1'b1, ILL_LAT,  1};
    vecs[12] = '{4'd0, 32'h00000001, 32'h1,        5'd10, 4'd15, 32'h00000000, 2'b00, 1'b0, 1'b1, ILL_LAT,  0};

    // reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'(1));
    check("reset_res_valid", 64'(res_valid), 64'(0));
    check("reset_res_vec", 64'(act_vec), 64'(0));
    check("reset_state", 64'(dbg_state), 64'(0));

    // directed vector table
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].id,
            pack_exp(vecs[i].data, vecs[i].rd, vecs[i].id, vecs[i].we, vecs[i].exc, vecs[i].flags),
            vecs[i].lat, vecs[i].hold);
    end

    // flush at cycle 10 of a conversion, then a normal add
    accept_only(4'd1, 32'h00BC614E, 32'h0, 5'd5, 4'd3, ok);
    check("flush_conv_accept", 64'(ok), 64'(1));
    repeat (11) @(negedge clk);
    check("flush_conv_busy", 64'(dbg_state), 64'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_conv_idle", 64'(dbg_state), 64'(0));
    check("flush_conv_ready", 64'(req_ready), 64'(1));
    check("flush_conv_valid", 64'(res_valid), 64'(0));
    watch_no_beat("flush_conv_no_beat", 40);
    issue(4'd2, 32'h00000012, 32'h00000034, 5'd4, 4'd10,
          pack_exp(32'h00000046, 5'd4, 4'd10, 1'b1, 1'b0, 2'b00), ADD_LAT, 0);

    // flush beats a same-cycle accept
    @(negedge clk);
    req_opcode = 4'd2;
    req_rs1    = 32'h1;
    req_rs2    = 32'h2;
    req_valid  = 1'b1;
    flush      = 1'b1;
    @(negedge clk);
    req_valid  = 1'b0;
    flush      = 1'b0;
    check("flush_accept_idle", 64'(dbg_state), 64'(0));
    watch_no_beat("flush_accept_no_beat", 20);

    // flush beats res_ready while a beat is pending
    accept_only(4'd5, 32'h0, 32'h0, 5'd1, 4'd1, ok);
    @(negedge clk);
    @(negedge clk);
    check("flush_done_pending", 64'(res_valid), 64'(1));
    flush     = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    res_ready = 1'b0;
    check("flush_done_valid", 64'(res_valid), 64'(0));
    check("flush_done_idle", 64'(dbg_state), 64'(0));

    // asynchronous reset mid-conversion
    accept_only(4'd1, 32'h0000FFFF, 32'h0, 5'd3, 4'd3, ok);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", 64'(dbg_state), 64'(0));
    check("async_rst_ready", 64'(req_ready), 64'(1));
    check("async_rst_vec", 64'({res_valid, act_vec}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // randomized requests against the reference model
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      a = $urandom;
      b = $urandom;
      if (sel <= 3) begin
        op = 4'd1;
      end else if (sel <= 8) begin
        op = 4'd2;
        if ($urandom_range(0, 3) != 0) begin
          a = to_bcd8(longint'($urandom_range(0, 99999999)));
          b = to_bcd8(longint'($urandom_range(0, 99999999)));
        end
      end else begin
        sel = int'($urandom_range(0, 13));
        op = (sel == 0) ? 4'd0 : 4'(sel + 2);
      end
      req_rd = 5'($urandom_range(0, 31));
      req_id = 4'($urandom_range(0, 15));
      model(op, a, b, req_rd, req_id, ev, lat);
      issue(op, a, b, req_rd, req_id, ev, lat, int'($urandom_range(0, 3)));
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
